clk_rst_seq: RTL
================

CLK_RST_SEQ -- requirements
Module: clk_rst_seq

Interface
REQ-001 Parameter RST_CYCLES, default 16: cycles mmcm_rst is held high per MMCM reset pulse.
REQ-002 Parameter STABLE_CYCLES, default 1024: consecutive synchronized-locked cycles required before system reset release.
REQ-003 Parameter LOCK_TIMEOUT, default 100000: cycles to wait for lock before re-pulsing mmcm_rst (1 ms at 100 MHz).
REQ-004 Parameter CNT_W, default 20: shared cycle-counter width; SHALL hold max(RST_CYCLES, STABLE_CYCLES, LOCK_TIMEOUT).
REQ-005 clk100 input 1: free-running 100 MHz board clock; sole clock.
REQ-006 rst input 1: synchronous, active-high reset.
REQ-007 locked input 1: MMCM LOCKED; asynchronous to clk100.
REQ-008 mmcm_rst output 1: drives MMCM RST, active high.
REQ-009 sys_rst output 1: active-high system reset; downstream domains resynchronize it.
REQ-010 ready output 1: high only in RUN.
REQ-011 relock_count output 8: saturating count of lock losses seen in RUN.
REQ-012 lock_err output 1: sticky lock-timeout flag.

Function
REQ-013 locked SHALL pass through a 2-flop synchronizer (locked_s); all decisions use locked_s, giving 2 cycles of input latency.
REQ-014 States SHALL be MMCM_RST, WAIT_LOCK, STABLE, RUN; all outputs registered.
REQ-015 MMCM_RST: mmcm_rst=1, sys_rst=1, counter increments; after exactly RST_CYCLES cycles go to WAIT_LOCK with counter cleared.
REQ-016 WAIT_LOCK: mmcm_rst=0, sys_rst=1; locked_s=1 -> STABLE, counter cleared.
REQ-017 STABLE: counter increments while locked_s=1; locked_s=0 -> WAIT_LOCK, counter cleared, no mmcm_rst pulse; counter reaching STABLE_CYCLES -> RUN.
REQ-018 RUN: sys_rst=0 and ready=1 from the first RUN cycle.
REQ-019 RUN with locked_s=0: next cycle sys_rst=1, ready=0, state MMCM_RST, relock_count increments, saturating at 255.
REQ-020 A locked glitch shorter than one clk100 cycle MAY be missed; a glitch of two or more cycles SHALL be acted on.
REQ-021 rst SHALL override every state, including mid-count.

Reset
REQ-022 On rst: state MMCM_RST, counter 0, synchronizer flops 0, mmcm_rst=1, sys_rst=1, ready=0, relock_count=0, lock_err=0.
REQ-023 The first MMCM_RST pulse after rst release SHALL last exactly RST_CYCLES cycles.

Configuration
REQ-024 Macro CLK_RST_TIMEOUT_EN defined: in WAIT_LOCK, counter reaching LOCK_TIMEOUT -> MMCM_RST with counter cleared, lock_err set; lock_err stays set until rst.
REQ-025 Macro CLK_RST_TIMEOUT_EN undefined: WAIT_LOCK waits indefinitely; lock_err tied 0; LOCK_TIMEOUT unused.

Structure
REQ-026 Package clk_rst_pkg SHALL hold the state enum and the default RST_CYCLES, STABLE_CYCLES and LOCK_TIMEOUT constants.
REQ-027 The synchronizer SHALL be sub-module sync_2ff (1-bit, reset value 0), reusable elsewhere.

Verification
Benches use RST_CYCLES=4, STABLE_CYCLES=8, LOCK_TIMEOUT=20.
REQ-028 rst released; locked rises 5 cycles after mmcm_rst falls -> mmcm_rst high exactly 4 cycles; sys_rst falls and ready rises 10 cycles after the locked edge (2 sync + 8 stable).
REQ-029 locked drops for 3 cycles at stable count 5 -> stable count restarts, sys_rst stays 1, no mmcm_rst pulse, RUN reached 8 cycles after locked_s returns.
REQ-030 locked falls in RUN -> sys_rst=1 and ready=0 by 3 cycles after the edge; 4-cycle mmcm_rst pulse follows; relock_count=1.
REQ-031 locked held 0 -> with CLK_RST_TIMEOUT_EN: mmcm_rst re-pulses every 24 cycles and lock_err=1 after the first timeout; without the macro: a single pulse, then indefinite wait with lock_err=0.
REQ-032 300 lock-loss/relock cycles -> relock_count saturates at 255 with no wrap.
REQ-033 rst asserted at stable count 6 -> on the next cycle every output is at its reset value and a fresh 4-cycle mmcm_rst pulse follows release.

Source files
------------

// File: rtl/clk_rst_pkg.sv
// Shared types and default timing constants for the clock/reset sequencer.
package clk_rst_pkg;

  typedef enum logic [1:0] {
    MMCM_RST  = 2'd0,
    WAIT_LOCK = 2'd1,
    STABLE    = 2'd2,
    RUN       = 2'd3
  } state_t;

  localparam int RST_CYCLES_DEF    = 16;
  localparam int STABLE_CYCLES_DEF = 1024;
  localparam int LOCK_TIMEOUT_DEF  = 100000;
  localparam int CNT_W_DEF         = 20;

  // Largest value any phase of the shared counter has to reach.
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/clk_rst_seq_sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level; resets to 0.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  // Two back-to-back flops give the first stage a full cycle to settle.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/clk_rst_seq.sv
// MMCM reset / lock sequencer: pulses the MMCM reset, waits for a lock that
// stays stable, then releases the system reset. Losing lock while running
// restarts the whole sequence.
// Optional build macro CLK_RST_TIMEOUT_EN: re-pulse the MMCM when lock does
// not arrive within LOCK_TIMEOUT cycles and raise the sticky lock_err flag.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// MMCM_RST  | mmcm_rst held high for RST_CYCLES cycles
// WAIT_LOCK | mmcm_rst released, waiting for synchronized lock
// STABLE    | lock seen, counting consecutive locked cycles
// RUN       | system reset released, ready high
module clk_rst_seq
  import clk_rst_pkg::*;
#(
  parameter int RST_CYCLES    = RST_CYCLES_DEF,
  parameter int STABLE_CYCLES = STABLE_CYCLES_DEF,
  parameter int LOCK_TIMEOUT  = LOCK_TIMEOUT_DEF,
  parameter int CNT_W         = CNT_W_DEF
) (
  input  logic       clk100,
  input  logic       rst,
  input  logic       locked,
  output logic       mmcm_rst,
  output logic       sys_rst,
  output logic       ready,
  output logic [7:0] relock_count,
  output logic       lock_err
);

  localparam int CNT_MAX = max3(RST_CYCLES, STABLE_CYCLES, LOCK_TIMEOUT);

  if ((CNT_MAX >> CNT_W) != 0) begin : g_cnt_w_check
    $error("clk_rst_seq: CNT_W too narrow for the configured cycle counts");
  end

  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RST_CYCLES - 1);
  // The WAIT_LOCK exit cycle already sampled lock high, so it is the first
  // of the STABLE_CYCLES locked cycles; STABLE needs STABLE_CYCLES-1 more.
  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 2);
`ifdef CLK_RST_TIMEOUT_EN
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
`endif

  logic             locked_s;
  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             relock_inc;
`ifdef CLK_RST_TIMEOUT_EN
  logic             timeout_hit;
`endif

  sync_2ff u_lock_sync (
    .clk (clk100),
    .rst (rst),
    .d   (locked),
    .q   (locked_s)
  );

  // Next-state and shared-counter decode.
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    relock_inc = 1'b0;
`ifdef CLK_RST_TIMEOUT_EN
    timeout_hit = 1'b0;
`endif
    case (state)
      MMCM_RST: begin
        if (cnt == RST_LAST) begin
          state_nxt = WAIT_LOCK;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
      WAIT_LOCK: begin
        if (locked_s) begin
          state_nxt = STABLE;
          cnt_nxt   = '0;
        end
`ifdef CLK_RST_TIMEOUT_EN
        else if (cnt == TIMEOUT_LAST) begin
          state_nxt   = MMCM_RST;
          cnt_nxt     = '0;
          timeout_hit = 1'b1;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
`endif
      end
      STABLE: begin
        if (!locked_s) begin
          state_nxt = WAIT_LOCK;
          cnt_nxt   = '0;
        end else if (cnt == STABLE_LAST) begin
          state_nxt = RUN;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
      RUN: begin
        if (!locked_s) begin
          state_nxt  = MMCM_RST;
          cnt_nxt    = '0;
          relock_inc = 1'b1;
        end
      end
      default: begin
        state_nxt = MMCM_RST;
        cnt_nxt   = '0;
      end
    endcase
  end

  // State, counter and outputs; outputs are decoded from the next state so
  // they change on the same edge as the state itself.
  always_ff @(posedge clk100) begin
    if (rst) begin
      state        <= MMCM_RST;
      cnt          <= '0;
      mmcm_rst     <= 1'b1;
      sys_rst      <= 1'b1;
      ready        <= 1'b0;
      relock_count <= 8'd0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      mmcm_rst <= (state_nxt == MMCM_RST);
      sys_rst  <= (state_nxt != RUN);
      ready    <= (state_nxt == RUN);
      if (relock_inc && (relock_count != 8'hFF)) begin
        relock_count <= relock_count + 8'd1;
      end
    end
  end

`ifdef CLK_RST_TIMEOUT_EN
  // Sticky lock-timeout flag, cleared only by rst.
  always_ff @(posedge clk100) begin
    if (rst) begin
      lock_err <= 1'b0;
    end else if (timeout_hit) begin
      lock_err <= 1'b1;
    end
  end
`else
  assign lock_err = 1'b0;
`endif

endmodule
